reg_word_pack: RTL and testbench
================================

REG_WORD_PACK -- requirements
Module: reg_word_pack

Interface
REQ-001 Parameter DWIDTH, default 32, width of one data word.
REQ-002 Parameter SEL_NUM, default 2, width of the slot index.
REQ-003 Parameter WORDS_OUT, default 1 << SEL_NUM, number of word slots per packed output.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-006 clr  input  1  synchronous discard of any partial pack.
REQ-007 s_valid  input  1  input word valid.
REQ-008 s_ready  output  1  block can accept an input word.
REQ-009 s_data  input  DWIDTH  input word.
REQ-010 s_last  input  1  the current word closes the pack early.
REQ-011 m_valid  output  1  packed output valid.
REQ-012 m_ready  input  1  downstream accepts the packed output.
REQ-013 m_data  output  DWIDTH*WORDS_OUT  packed words; slot k is at bits [k*DWIDTH +: DWIDTH].
REQ-014 m_mask  output  WORDS_OUT  bit k set means slot k holds a received word.
REQ-015 m_last  output  1  the pack was closed by s_last.
REQ-016 fill  output  SEL_NUM  next slot index to be written (status).

Function
REQ-017 An input transfer occurs on an edge with s_valid && s_ready; an output transfer occurs on an edge with m_valid && m_ready.
REQ-018 The FSM has two states: FILL (assembling, m_valid=0) and HOLD (pack complete, m_valid=1).
REQ-019 In FILL, s_ready=1.
REQ-020 In HOLD, s_ready=m_ready (pass-through), so a new word is accepted on the same edge the pack drains.
REQ-021 On an input transfer, s_data is registered into slot fill, m_mask[fill] is set, and fill increments.
REQ-022 When the written slot is WORDS_OUT-1, or s_last=1, the FSM goes to HOLD, m_last<=s_last, and fill<=0.
REQ-023 Latency: m_valid rises on the first edge after the closing input transfer.
REQ-024 Slots whose m_mask bit is 0 read as all-zero in m_data.
REQ-025 HOLD, output transfer, no input transfer: go to FILL; clear m_data, m_mask and m_last.
REQ-026 HOLD, output and input transfer on the same edge: start a fresh pack with the new word in slot 0 and m_mask=1 (others 0). Go to HOLD if s_last=1 or WORDS_OUT=1; otherwise go to FILL with fill=1.
REQ-027 While m_valid=1 and no output transfer occurs, m_data, m_mask and m_last hold stable.
REQ-028 clr=1 in FILL clears m_data, m_mask and fill to 0 and ignores any simultaneous input word.
REQ-029 clr=1 in HOLD has no effect; a completed pack is never discarded.
REQ-030 fill wraps modulo WORDS_OUT and never exceeds WORDS_OUT-1.
REQ-031 s_last on slot WORDS_OUT-1 yields a full pack with m_last=1.

Reset
REQ-032 rst_n=0 forces the following immediately, independent of clk, and holds them while low: state=FILL, m_valid=0, m_last=0, m_mask=0, m_data=0, fill=0.
REQ-033 s_ready=0 while rst_n=0; s_ready=1 on the first edge after release.
REQ-034 Reset asserted mid-pack or in HOLD discards all contents; no partial output follows release.

Verification (DWIDTH=8, SEL_NUM=2)
REQ-035 Full pack: inputs 0x11,0x22,0x33,0x44 on consecutive cycles, m_ready=1 -> next cycle m_data=0x44332211, m_mask=0xF, m_last=0.
REQ-036 Early close: inputs 0xA1, then 0xB2 with s_last=1 -> m_data=0x0000B2A1, m_mask=0x3, m_last=1.
REQ-037 Backpressure: pack complete, m_ready=0 for 5 cycles -> m_valid stays 1, data stable, s_ready=0; with m_ready=1 and s_valid=1 (0x55) on the same edge -> next m_mask=0x1, fill=1, slot0=0x55.
REQ-038 Streaming: 12 back-to-back words, m_ready tied 1 -> 3 packs, no stall cycles on s_ready, word order preserved.
REQ-039 clr after 2 words in FILL -> fill=0, m_mask=0; the next 4 words form a clean pack. clr in HOLD -> pack unchanged.
REQ-040 Async reset: assert rst_n=0 between edges during HOLD -> m_valid and m_mask go to 0 without a clock edge.

Source files
------------

// File: rtl/reg_word_pack_if.sv
// reg_word_pack_if: handshake bundle for reg_word_pack.
//   s_valid/s_ready/s_data/s_last : one-word input stream
//   m_valid/m_ready/m_data/m_mask/m_last : packed output stream
// modport master: the packer itself (accepts words, drives packed output).
// modport slave : the surrounding environment (drives words, accepts packs).
interface reg_word_pack_if #(
   parameter int DWIDTH    = 32,
   parameter int WORDS_OUT = 4
);
   logic                          s_valid;
   logic                          s_ready;
   logic [DWIDTH-1:0]             s_data;
   logic                          s_last;
   logic                          m_valid;
   logic                          m_ready;
   logic [DWIDTH*WORDS_OUT-1:0]   m_data;
   logic [WORDS_OUT-1:0]          m_mask;
   logic                          m_last;

   modport master (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data, m_mask, m_last
   );

   modport slave (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_mask, m_last
   );
endinterface

// File: rtl/reg_word_pack.sv
// reg_word_pack: packs up to WORDS_OUT input words of DWIDTH bits into one
// wide output word. A pack closes when the last slot is written or when
// s_last accompanies a word; it is then held until the consumer takes it.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   clr   - synchronous discard of a partial pack (ignored while holding)
//   bus   - reg_word_pack_if.master (input word stream + packed output)
//   fill  - next slot index to be written
module reg_word_pack #(
   parameter int DWIDTH    = 32,
   parameter int SEL_NUM   = 2,
   parameter int WORDS_OUT = 1 << SEL_NUM
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   reg_word_pack_if.master     bus,
   output logic [SEL_NUM-1:0]  fill
);

   localparam int                 PW        = DWIDTH * WORDS_OUT;
   localparam logic [SEL_NUM-1:0] LAST_SLOT = SEL_NUM'(WORDS_OUT - 1);

   typedef enum logic {
      FILL,
      HOLD
   } state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        data_q, data_d;
   logic [WORDS_OUT-1:0] mask_q, mask_d;
   logic                 last_q, last_d;
   logic [SEL_NUM-1:0]   fill_q, fill_d;
   logic                 rdy_en_q;

   logic s_ready_w;
   logic in_xfer;
   logic out_xfer;

   // s_ready is held low through reset and until the first edge after release.
   assign s_ready_w = rdy_en_q && ((state_q == FILL) || bus.m_ready);
   assign in_xfer   = bus.s_valid && s_ready_w;
   assign out_xfer  = (state_q == HOLD) && bus.m_ready;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mask_d  = mask_q;
      last_d  = last_q;
      fill_d  = fill_q;
      case (state_q)
         FILL: begin
            if (clr) begin
               data_d = '0;
               mask_d = '0;
               fill_d = '0;
            end else if (in_xfer) begin
               for (int unsigned k = 0; k < WORDS_OUT; k++) begin
                  if (fill_q == SEL_NUM'(k)) begin
                     data_d[k*DWIDTH +: DWIDTH] = bus.s_data;
                     mask_d[k]                  = 1'b1;
                  end
               end
               if ((fill_q == LAST_SLOT) || bus.s_last) begin
                  state_d = HOLD;
                  last_d  = bus.s_last;
                  fill_d  = '0;
               end else begin
                  fill_d = fill_q + SEL_NUM'(1);
               end
            end
         end
         HOLD: begin
            // clr is deliberately ignored here: a completed pack is never dropped.
            if (out_xfer) begin
               state_d = FILL;
               data_d  = '0;
               mask_d  = '0;
               last_d  = 1'b0;
               fill_d  = '0;
               // Word accepted on the draining edge opens a fresh pack in slot 0.
               if (in_xfer) begin
                  data_d[DWIDTH-1:0] = bus.s_data;
                  mask_d[0]          = 1'b1;
                  if (bus.s_last || (WORDS_OUT == 1)) begin
                     state_d = HOLD;
                     last_d  = bus.s_last;
                  end else begin
                     fill_d = SEL_NUM'(1);
                  end
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FILL;
         data_q   <= '0;
         mask_q   <= '0;
         last_q   <= 1'b0;
         fill_q   <= '0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         mask_q   <= mask_d;
         last_q   <= last_d;
         fill_q   <= fill_d;
         rdy_en_q <= 1'b1;
      end
   end

   assign bus.s_ready = s_ready_w;
   assign bus.m_valid = (state_q == HOLD);
   assign bus.m_data  = data_q;
   assign bus.m_mask  = mask_q;
   assign bus.m_last  = last_q;
   assign fill        = fill_q;

endmodule

// File: tb/tb_reg_word_pack.sv
// Bench for reg_word_pack with DWIDTH=8, SEL_NUM=2 (4 slots per pack).
module tb_reg_word_pack;

   localparam int DW = 8;
   localparam int SN = 2;
   localparam int WO = 4;

   logic          clk;
   logic          rst_n;
   logic          clr;
   logic [SN-1:0] fill;

   reg_word_pack_if #(.DWIDTH(DW), .WORDS_OUT(WO)) bus ();

   reg_word_pack #(.DWIDTH(DW), .SEL_NUM(SN), .WORDS_OUT(WO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus),
      .fill  (fill)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   // Reference model: the current pack is simply a list of received words.
   logic [7:0] mq[$];
   bit         mdone;
   bit         mlast;
   bit         mrdy_en;

   function automatic void model_reset();
      mq.delete();
      mdone   = 1'b0;
      mlast   = 1'b0;
      mrdy_en = 1'b0;
   endfunction

   function automatic bit model_srdy(input bit mr);
      return mrdy_en && (!mdone || mr);
   endfunction

   function automatic void model_step(input bit v, input logic [7:0] d,
                                      input bit l, input bit c, input bit mr);
      bit acc;
      bit was;
      acc = v && model_srdy(mr);
      was = mdone;
      if (was && mr) begin
         mq.delete();
         mdone = 1'b0;
         mlast = 1'b0;
      end
      if (!was && c) begin
         mq.delete();
      end else if (acc) begin
         mq.push_back(d);
         if (mq.size() == WO || l) begin
            mdone = 1'b1;
            mlast = l;
         end
      end
      mrdy_en = 1'b1;
   endfunction

   function automatic logic [31:0] model_data();
      logic [31:0] r;
      r = '0;
      foreach (mq[i]) r[i*8 +: 8] = mq[i];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      logic [31:0] em;
      em = (32'd1 << mq.size()) - 32'd1;
      chk({tag, " m_valid"}, 32'(bus.m_valid), 32'(mdone));
      chk({tag, " m_data"},  bus.m_data, model_data());
      chk({tag, " m_mask"},  32'(bus.m_mask), em);
      chk({tag, " m_last"},  32'(bus.m_last), 32'(mlast));
      chk({tag, " fill"},    32'(fill), mdone ? 32'd0 : 32'(mq.size()));
      chk({tag, " s_ready"}, 32'(bus.s_ready), 32'(model_srdy(bus.m_ready)));
   endtask

   // Called at posedge+1; drives inputs, checks s_ready before the edge,
   // advances the model and checks all outputs one step after the edge.
   task automatic apply(input bit v, input logic [7:0] d, input bit l,
                        input bit c, input bit mr, input string tag);
      bus.s_valid = v;
      bus.s_data  = d;
      bus.s_last  = l;
      clr         = c;
      bus.m_ready = mr;
      #1;
      chk({tag, " s_ready_pre"}, 32'(bus.s_ready), 32'(model_srdy(mr)));
      model_step(v, d, l, c, mr);
      @(posedge clk);
      #1;
      chk_model(tag);
   endtask

   typedef struct {
      bit          v;
      logic [7:0]  d;
      bit          l;
      bit          c;
      bit          mr;
      bit          e_valid;
      logic [31:0] e_data;
      logic [3:0]  e_mask;
      bit          e_last;
      logic [1:0]  e_fill;
   } vec_t;

   vec_t tbl[25];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] packs[$];
      logic [7:0]  w[12];
      logic [31:0] ep;

      //          v  d      l  c  mr  ev  data           mask  el fill
      tbl[0]  = '{1, 8'h11, 0, 0, 1,  0, 32'h00000011, 4'h1, 0, 2'd1};
      tbl[1]  = '{1, 8'h22, 0, 0, 1,  0, 32'h00002211, 4'h3, 0, 2'd2};
      tbl[2]  = '{1, 8'h33, 0, 0, 1,  0, 32'h00332211, 4'h7, 0, 2'd3};
      tbl[3]  = '{1, 8'h44, 0, 0, 1,  1, 32'h44332211, 4'hF, 0, 2'd0};
      tbl[4]  = '{0, 8'h00, 0, 0, 1,  0, 32'h00000000, 4'h0, 0, 2'd0};
      tbl[5]  = '{1, 8'hA1, 0, 0, 1,  0, 32'h000000A1, 4'h1, 0, 2'd1};
      tbl[6]  = '{1, 8'hB2, 1, 0, 1,  1, 32'h0000B2A1, 4'h3, 1, 2'd0};
      tbl[7]  = '{0, 8'h00, 0, 0, 1,  0, 32'h00000000, 4'h0, 0, 2'd0};
      tbl[8]  = '{1, 8'h01, 0, 0, 1,  0, 32'h00000001, 4'h1, 0, 2'd1};
      tbl[9]  = '{1, 8'h02, 0, 0, 1,  0, 32'h00000201, 4'h3, 0, 2'd2};
      tbl[10] = '{1, 8'h03, 0, 1, 1,  0, 32'h00000000, 4'h0, 0, 2'd0};
      tbl[11] = '{1, 8'h05, 0, 0, 1,  0, 32'h00000005, 4'h1, 0, 2'd1};
      tbl[12] = '{1, 8'h06, 0, 0, 1,  0, 32'h00000605, 4'h3, 0, 2'd2};
      tbl[13] = '{1, 8'h07, 0, 0, 1,  0, 32'h00070605, 4'h7, 0, 2'd3};
      tbl[14] = '{1, 8'h08, 0, 0, 1,  1, 32'h08070605, 4'hF, 0, 2'd0};
      tbl[15] = '{0, 8'h00, 0, 1, 0,  1, 32'h08070605, 4'hF, 0, 2'd0};
      tbl[16] = '{0, 8'h00, 0, 0, 1,  0, 32'h00000000, 4'h0, 0, 2'd0};
      tbl[17] = '{1, 8'h9A, 0, 0, 1,  0, 32'h0000009A, 4'h1, 0, 2'd1};
      tbl[18] = '{1, 8'h9B, 0, 0, 1,  0, 32'h00009B9A, 4'h3, 0, 2'd2};
      tbl[19] = '{1, 8'h9C, 0, 0, 1,  0, 32'h009C9B9A, 4'h7, 0, 2'd3};
      tbl[20] = '{1, 8'h9D, 1, 0, 0,  1, 32'h9D9C9B9A, 4'hF, 1, 2'd0};
      tbl[21] = '{1, 8'hE1, 0, 0, 1,  0, 32'h000000E1, 4'h1, 0, 2'd1};
      tbl[22] = '{1, 8'hE2, 1, 0, 1,  1, 32'h0000E2E1, 4'h3, 1, 2'd0};
      tbl[23] = '{1, 8'hE3, 1, 0, 1,  1, 32'h000000E3, 4'h1, 1, 2'd0};
      tbl[24] = '{0, 8'h00, 0, 0, 1,  0, 32'h00000000, 4'h0, 0, 2'd0};

      // Reset values, before any clock edge and while held.
      rst_n       = 1'b0;
      clr         = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b1;
      model_reset();
      #2;
      chk("rst m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst m_data",  bus.m_data, 32'd0);
      chk("rst m_mask",  32'(bus.m_mask), 32'd0);
      chk("rst m_last",  32'(bus.m_last), 32'd0);
      chk("rst fill",    32'(fill), 32'd0);
      chk("rst s_ready", 32'(bus.s_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rst held s_ready", 32'(bus.s_ready), 32'd0);
      rst_n = 1'b1;
      apply(0, 8'h00, 0, 0, 1, "post_rst");

      // Table vectors.
      for (int i = 0; i < 25; i++) begin
         apply(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].c, tbl[i].mr, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d e_valid", i), 32'(bus.m_valid), 32'(tbl[i].e_valid));
         chk($sformatf("tbl%0d e_data", i),  bus.m_data, tbl[i].e_data);
         chk($sformatf("tbl%0d e_mask", i),  32'(bus.m_mask), 32'(tbl[i].e_mask));
         chk($sformatf("tbl%0d e_last", i),  32'(bus.m_last), 32'(tbl[i].e_last));
         chk($sformatf("tbl%0d e_fill", i),  32'(fill), 32'(tbl[i].e_fill));
      end

      // Backpressure: full pack held for 5 cycles, then drain with new word.
      apply(1, 8'h11, 0, 0, 0, "bp_w0");
      apply(1, 8'h22, 0, 0, 0, "bp_w1");
      apply(1, 8'h33, 0, 0, 0, "bp_w2");
      apply(1, 8'h44, 0, 0, 0, "bp_w3");
      for (int i = 0; i < 5; i++) begin
         apply(1, 8'h99, 0, 0, 0, $sformatf("bp_hold%0d", i));
         chk("bp m_valid", 32'(bus.m_valid), 32'd1);
         chk("bp m_data",  bus.m_data, 32'h44332211);
         chk("bp s_ready", 32'(bus.s_ready), 32'd0);
      end
      apply(1, 8'h55, 0, 0, 1, "bp_drain");
      chk("bp_drain m_mask", 32'(bus.m_mask), 32'h1);
      chk("bp_drain fill",   32'(fill), 32'd1);
      chk("bp_drain slot0",  bus.m_data, 32'h00000055);
      chk("bp_drain m_valid", 32'(bus.m_valid), 32'd0);

      // Streaming: 12 back-to-back words with m_ready tied high.
      apply(0, 8'h00, 0, 1, 1, "stream_clr");
      for (int i = 0; i < 12; i++) begin
         w[i] = 8'(8'h30 + 8'(i * 7));
         apply(1, w[i], 0, 0, 1, $sformatf("stream%0d", i));
         chk("stream s_ready", 32'(bus.s_ready), 32'd1);
         if (bus.m_valid) packs.push_back(bus.m_data);
      end
      chk("stream pack count", 32'(packs.size()), 32'd3);
      for (int j = 0; j < 3; j++) begin
         ep = {w[4*j+3], w[4*j+2], w[4*j+1], w[4*j]};
         if (j < packs.size()) chk($sformatf("stream pack%0d", j), packs[j], ep);
      end
      apply(0, 8'h00, 0, 0, 1, "stream_tail");

      // Asynchronous reset between edges while holding a pack.
      apply(1, 8'hC1, 0, 0, 0, "ar_w0");
      apply(1, 8'hC2, 0, 0, 0, "ar_w1");
      apply(1, 8'hC3, 1, 0, 0, "ar_w2");
      chk("ar pre m_valid", 32'(bus.m_valid), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar m_valid", 32'(bus.m_valid), 32'd0);
      chk("ar m_mask",  32'(bus.m_mask), 32'd0);
      chk("ar m_data",  bus.m_data, 32'd0);
      chk("ar s_ready", 32'(bus.s_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      apply(0, 8'h00, 0, 0, 1, "ar_release");
      chk("ar_release m_valid", 32'(bus.m_valid), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 9) < 7), 8'($urandom()), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0),
               $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
